imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Write-side counterpart of the instruction fetch path. It receives a byte stream over a valid/ready handshake and assembles the bytes into 32-bit instruction words. Each word is written into the instruction memory at consecutive word addresses starting at 0. While loading, it holds the CPU off via cpu_hold, then signals completion.

Parameters:
ADDR_W, 6, word-address width of instruction memory (depth = 2^ADDR_W words; matches 6-bit fetch address)
LITTLE_ENDIAN, 1, 1: first byte of each word goes to [7:0]; 0: first byte goes to [31:24]

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE
word_count  in  ADDR_W+1  number of words to load, sampled on accepted start
abort  in  1  terminate an active load with error
in_valid  in  1  byte-stream valid
in_data  in  8  byte-stream data
in_ready  out  1  byte accepted when in_valid & in_ready
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  word address of write
mem_wdata  out  32  assembled instruction word
cpu_hold  out  1  high while a load is in progress
done  out  1  level; load finished (successfully or not)
error  out  1  level; valid when done=1
words_loaded  out  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (sync, rst=1 at rising edge): state IDLE. in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0, words_loaded=0. Byte index and assembly register cleared.
- Reset mid-load: partial word discarded; no further mem_we; already-written words untouched.
- All outputs registered, except in_ready, which is decoded from state (1 only in RECV and CHECK).
- States: IDLE, RECV, WRITE, CHECK (feature only), DONE.
- IDLE/DONE + start:
  - clear done, error, words_loaded; latch word_count.
  - count=0 -> DONE next cycle, error=0.
  - count > 2^ADDR_W -> DONE next cycle, error=1.
  - No mem_we in either case; otherwise -> RECV with addr=0, byte_idx=0, cpu_hold=1.
- RECV:
  - Each accepted byte is placed in lane byte_idx per LITTLE_ENDIAN; byte_idx increments (2-bit, wraps).
  - 4th accepted byte -> WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=addr, mem_wdata=assembled word; in_ready=0.
  - Next cycle: addr+1, words_loaded+1.
  - If words_loaded reaches count -> DONE (or CHECK); else -> RECV.
- Latency: last byte of a word accepted in cycle T -> mem_we asserted in cycle T+1. Final word -> done=1 in T+2 (without feature).
- Address never wraps: max count 2^ADDR_W, so the last address is 2^ADDR_W-1.
- DONE: done=1, cpu_hold=0, in_ready=0. Stays until start or rst.
- abort in RECV/WRITE/CHECK -> DONE next cycle with error=1.
  - If abort coincides with the WRITE cycle, that write still occurs.
  - abort has priority over byte acceptance in the same cycle (byte not consumed, in_ready forced 0).
- start while RECV/WRITE/CHECK is ignored.
- in_valid gaps and stalls are allowed indefinitely; no timeout.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Defined:
  - A running XOR of every accepted data byte is kept.
  - After the final WRITE, go to CHECK, where in_ready=1; accept one checksum byte.
  - Mismatch -> error=1; then DONE.
  - count=0 skips CHECK.
- Undefined:
  - No CHECK state and no XOR register.
  - error arises only from an oversize count or abort.

Test Plan:
1. rst held 2 cycles mid-traffic -> all outputs 0; in_ready=0; state IDLE.
2. start, word_count=2, bytes 78 56 34 12 EF BE AD DE (LITTLE_ENDIAN=1, back-to-back valid) -> expect:
   - mem_we at addr 0 data 0x12345678 and addr 1 data 0xDEADBEEF, each one cycle after its 4th byte.
   - done=1, error=0, words_loaded=2, cpu_hold falls with done.
3. Same as 2 with in_valid toggled every other cycle, plus a byte presented during WRITE -> identical writes; byte held during WRITE not consumed until RECV.
4. word_count=0 -> done=1 next cycle, no mem_we, error=0. word_count=65 (ADDR_W=6) -> done=1, error=1, no mem_we.
5. rst after 2 bytes of word 0 -> no mem_we. Then start, count=1, bytes 01 02 03 04 -> write addr 0 data 0x04030201.
6. With IMEM_LOADER_CHECKSUM_EN, stimulus of 2 plus checksum 0x2A -> done=1, error=0. Checksum 0x2B -> error=1. abort during CHECK -> error=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream over valid/ready, packs each group of
// four bytes into a 32-bit instruction word and writes the words into the
// instruction memory at word addresses 0, 1, 2, ... .  cpu_hold is high while
// a load is in progress.  done/error report the result of the last load.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, word_count   begin a load of word_count words (IDLE/DONE only)
//   abort               end an active load with error
//   in_valid/in_data/in_ready  byte stream handshake
//   mem_we/mem_addr/mem_wdata  instruction-memory write port
//   cpu_hold, done, error, words_loaded  status
//
// Optional build macro IMEM_LOADER_CHECKSUM_EN: after the last word one extra
// byte is accepted and compared against the XOR of all data bytes; a
// mismatch reports error.
module imem_loader #(
  parameter int ADDR_W        = 6,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic              err_nxt;
  logic              hold_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_idx;
  logic [1:0]        lane;
  logic [31:0]       asm_word;
  logic [31:0]       word_nxt;
  logic              accept;
  logic              last_word;
  logic              start_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xsum;
`endif

  // abort wins over a byte offered in the same cycle
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = ((state == RECV) || (state == CHECK)) && !abort;
`else
  assign in_ready = (state == RECV) && !abort;
`endif
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  // words_loaded has not yet counted the word being written in WRITE
  assign last_word = (words_loaded + (ADDR_W+1)'(1)) == cnt;
  assign lane      = LITTLE_ENDIAN ? byte_idx : ~byte_idx;

  always_comb begin
    word_nxt = asm_word;
    for (int i = 0; i < 4; i++)
      if (lane == i[1:0]) word_nxt[i*8 +: 8] = in_data;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = error;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          err_nxt = 1'b0;
          if (word_count == '0)          state_nxt = DONE;
          else if (word_count > MAX_CNT) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
          end
          else                           state_nxt = RECV;
        end
      end
      RECV: begin
        if (abort) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (accept && (byte_idx == 2'd3)) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (abort) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (accept) begin
          state_nxt = DONE;
          err_nxt   = (in_data != xsum);
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign hold_nxt = (state_nxt == RECV) || (state_nxt == WRITE) || (state_nxt == CHECK);
`else
  assign hold_nxt = (state_nxt == RECV) || (state_nxt == WRITE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      error        <= 1'b0;
      done         <= 1'b0;
      cpu_hold     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      cnt          <= '0;
      addr         <= '0;
      byte_idx     <= '0;
      asm_word     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xsum         <= '0;
`endif
    end else begin
      // status outputs are registered images of the next state
      state    <= state_nxt;
      error    <= err_nxt;
      done     <= (state_nxt == DONE);
      cpu_hold <= hold_nxt;
      mem_we   <= (state_nxt == WRITE);

      if (start_ok) begin
        cnt          <= word_count;
        words_loaded <= '0;
        addr         <= '0;
        byte_idx     <= '0;
        asm_word     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xsum         <= '0;
`endif
      end

      if (accept && (state == RECV)) begin
        byte_idx <= byte_idx + 2'd1;
        asm_word <= word_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xsum     <= xsum ^ in_data;
`endif
        // present the finished word together with mem_we next cycle
        if (byte_idx == 2'd3) begin
          mem_addr  <= addr;
          mem_wdata <= word_nxt;
        end
      end

      // the write happens even if abort arrives in this cycle, so count it
      if (state == WRITE) begin
        addr         <= addr + ADDR_W'(1);
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed byte streams; expected writes are queued
// by the driver and popped by a monitor that watches mem_we.
module tb_imem_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .LITTLE_ENDIAN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  int  last_we_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every write must match the head of the queue, in the expected cycle
  always @(negedge clk) begin
    if (mem_we) begin
      vectors++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_write: got addr %0d data %h, expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL write: got addr %0d data %h cyc %0d, expected addr %0d data %h cyc %0d",
                   mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
      check("in_ready_during_write", {31'd0, in_ready}, 32'd0);
    end
  end

  task automatic do_start(input logic [ADDR_W:0] n);
    @(negedge clk);
    word_count = n;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // offer one byte and return once it is taken; acc_cyc is the accepting cycle
  task automatic send_byte(input logic [7:0] b, input bit gap, output int acc_cyc);
    int n;
    n = 0;
    if (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_timeout: got no in_ready, expected byte %h accepted", b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b0, b1, b2, b3, input bit gap,
                           input logic [ADDR_W-1:0] a, input logic [31:0] w);
    int c;
    logic [7:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int i = 0; i < 4; i++) begin
      send_byte(bs[i], gap, c);
      if (i == 3) exp_q.push_back('{addr: a, data: w, cyc: c + 1});
    end
  endtask

  task automatic finish_load(input logic [7:0] ck);
`ifdef IMEM_LOADER_CHECKSUM_EN
    int c;
    send_byte(ck, 1'b0, c);
`else
    if (ck == 8'hxx) $display("unused");
`endif
  endtask

  task automatic wait_done(input string name, input logic exp_err,
                           input logic [ADDR_W:0] exp_wl, output int done_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_error"}, {31'd0, error}, {31'd0, exp_err});
    check({name, "_words"}, {25'd0, words_loaded}, {25'd0, exp_wl});
    check({name, "_hold"}, {31'd0, cpu_hold}, 32'd0);
  endtask

  initial begin
    int dc, c;
    rst = 1'b1; start = 1'b0; word_count = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);

    // main load, back-to-back bytes
    do_start(7'd2);
    @(negedge clk);
    check("load_hold", {31'd0, cpu_hold}, 32'd1);
    send_word(8'h78, 8'h56, 8'h34, 8'h12, 1'b0, 6'd0, 32'h12345678);
    send_word(8'hEF, 8'hBE, 8'hAD, 8'hDE, 1'b0, 6'd1, 32'hDEADBEEF);
    finish_load(8'h2A);
    wait_done("b2b", 1'b0, 7'd2, dc);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("done_latency", dc, last_we_cyc + 1);
`endif

    // same with gaps, plus an ignored start mid-load
    do_start(7'd2);
    send_word(8'h78, 8'h56, 8'h34, 8'h12, 1'b1, 6'd0, 32'h12345678);
    @(negedge clk);
    start = 1'b1; word_count = 7'd1;
    @(posedge clk); #1 start = 1'b0;
    send_word(8'hEF, 8'hBE, 8'hAD, 8'hDE, 1'b1, 6'd1, 32'hDEADBEEF);
    finish_load(8'h2A);
    wait_done("gap", 1'b0, 7'd2, dc);

    // zero and oversize counts
    do_start(7'd0);
    @(negedge clk);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_error", {31'd0, error}, 32'd0);
    check("zero_words", {25'd0, words_loaded}, 32'd0);
    do_start(7'd65);
    @(negedge clk);
    check("over_done", {31'd0, done}, 32'd1);
    check("over_error", {31'd0, error}, 32'd1);
    check("over_hold", {31'd0, cpu_hold}, 32'd0);

    // reset mid-load discards the partial word
    do_start(7'd2);
    send_byte(8'hAA, 1'b0, c);
    send_byte(8'hBB, 1'b0, c);
    in_valid = 1'b1; in_data = 8'hCC;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_addr", {26'd0, mem_addr}, 32'd0);
    check("mid_rst_words", {25'd0, words_loaded}, 32'd0);
    do_start(7'd1);
    send_word(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 6'd0, 32'h04030201);
    finish_load(8'h04);
    wait_done("after_rst", 1'b0, 7'd1, dc);

    // abort in RECV with a byte offered: byte refused, no write
    do_start(7'd1);
    send_byte(8'h11, 1'b0, c);
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h22;
    #1 check("abort_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1 abort = 1'b0; in_valid = 1'b0;
    wait_done("abort_recv", 1'b1, 7'd0, dc);

    // abort coinciding with WRITE: the write still happens
    do_start(7'd2);
    send_word(8'h0D, 8'hF0, 8'hAD, 8'h8B, 1'b0, 6'd0, 32'h8BADF00D);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done("abort_write", 1'b1, 7'd1, dc);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_start(7'd2);
    send_word(8'h78, 8'h56, 8'h34, 8'h12, 1'b0, 6'd0, 32'h12345678);
    send_word(8'hEF, 8'hBE, 8'hAD, 8'hDE, 1'b0, 6'd1, 32'hDEADBEEF);
    finish_load(8'h2B);
    wait_done("bad_sum", 1'b1, 7'd2, dc);
    do_start(7'd1);
    send_word(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 6'd0, 32'h04030201);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done("abort_check", 1'b1, 7'd1, dc);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
